// File: rtl/cov_matrix_pkg.sv
// cov_pkg: shared types and helpers for the covariance builder and the
// downstream pivot-selection stage.
//   - cov_state_t : builder FSM states
//   - cov_elem_t / cov_sample_t / cov_matrix_t : default-size element, sample
//     vector and matrix types. The packed layout (row-major, element [r][c]
//     at bit offset (r*N+c)*WIDTH) is the same as the flat matrix_out port.
//   - P, PAIR_I, PAIR_J : upper-triangle pair count and row-major pair tables
//     for the default size.
//   - pair_count / pair_row / pair_col / pair_index : the same mapping for
//     any N, usable in constant expressions.
package cov_pkg;

    typedef enum logic [1:0] {
        ACCUM   = 2'd0,
        COMPUTE = 2'd1,
        PUBLISH = 2'd2
    } cov_state_t;

    localparam int COV_WIDTH    = 16;
    localparam int COV_N_STOCKS = 4;

    typedef logic signed [COV_WIDTH-1:0] cov_elem_t;
    typedef logic [COV_N_STOCKS-1:0][COV_WIDTH-1:0] cov_sample_t;
    typedef logic [COV_N_STOCKS-1:0][COV_N_STOCKS-1:0][COV_WIDTH-1:0] cov_matrix_t;

    function automatic int pair_count(input int n);
        return n * (n + 1) / 2;
    endfunction

    // Row of the k-th upper-triangle pair in row-major order.
    function automatic int pair_row(input int n, input int k);
        int rem;
        int row;
        rem = k;
        row = 0;
        while ((row < n) && (rem >= n - row)) begin
            rem = rem - (n - row);
            row = row + 1;
        end
        return row;
    endfunction

    // Column of the k-th upper-triangle pair in row-major order.
    function automatic int pair_col(input int n, input int k);
        int rem;
        int row;
        rem = k;
        row = 0;
        while ((row < n) && (rem >= n - row)) begin
            rem = rem - (n - row);
            row = row + 1;
        end
        return row + rem;
    endfunction

    // Inverse mapping: pair (i,j), i<=j, to its row-major index.
    function automatic int pair_index(input int n, input int i, input int j);
        return i * n - (i * (i - 1)) / 2 + (j - i);
    endfunction

    localparam int P = pair_count(COV_N_STOCKS);
    localparam int PAIR_I [P] = '{0, 0, 0, 0, 1, 1, 1, 2, 2, 3};
    localparam int PAIR_J [P] = '{0, 1, 2, 3, 1, 2, 3, 2, 3, 3};

endpackage

// File: rtl/cov_matrix_finalize.sv
// cov_finalize: turns the raw window sums of one stock pair into a saturated
// population covariance:
//   cov = sat( (sum_xy - ((sum_xi*sum_xj) >>> L)) >>> L )
// Both shifts are arithmetic, so they floor toward minus infinity.
// Purely combinational; the builder time-shares a single instance.
// Ports:
//   sum_xi, sum_xj : signed sums of the two stocks, WIDTH+L bits
//   sum_xy         : signed sum of products of the pair, 2*WIDTH+L bits
//   cov            : signed result clamped to WIDTH bits
module cov_finalize
    import cov_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int LOG_SAMPLES = 4
) (
    input  logic [WIDTH+LOG_SAMPLES-1:0]   sum_xi,
    input  logic [WIDTH+LOG_SAMPLES-1:0]   sum_xj,
    input  logic [2*WIDTH+LOG_SAMPLES-1:0] sum_xy,
    output logic [WIDTH-1:0]               cov
);

    localparam int SXW  = WIDTH + LOG_SAMPLES;
    localparam int SXYW = 2 * WIDTH + LOG_SAMPLES;
    localparam int MW   = 2 * SXW;
    // Two guard bits above the product width: the difference of two
    // in-range values can never wrap at this width.
    localparam int EW   = MW + 2;

    localparam logic signed [EW-1:0] SAT_MAX = {{(EW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [EW-1:0] SAT_MIN = {{(EW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    logic signed [MW-1:0] xi_e;
    logic signed [MW-1:0] xj_e;
    logic signed [MW-1:0] mprod;
    logic signed [MW-1:0] mshift;
    logic signed [EW-1:0] sxy_e;
    logic signed [EW-1:0] diff;
    logic signed [EW-1:0] cov_wide;

    assign xi_e   = {{(MW-SXW){sum_xi[SXW-1]}}, sum_xi};
    assign xj_e   = {{(MW-SXW){sum_xj[SXW-1]}}, sum_xj};
    // Operands are sign-extended to the full product width, so the product
    // of the two sums is exact.
    assign mprod  = xi_e * xj_e;
    assign mshift = mprod >>> LOG_SAMPLES;

    assign sxy_e    = {{(EW-SXYW){sum_xy[SXYW-1]}}, sum_xy};
    assign diff     = sxy_e - {{(EW-MW){mshift[MW-1]}}, mshift};
    assign cov_wide = diff >>> LOG_SAMPLES;

    always_comb begin
        cov = cov_wide[WIDTH-1:0];
        if (cov_wide > SAT_MAX) begin
            cov = SAT_MAX[WIDTH-1:0];
        end else if (cov_wide < SAT_MIN) begin
            cov = SAT_MIN[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/cov_matrix.sv
// cov_matrix: streaming covariance-matrix builder.
// Accumulates 2^LOG_SAMPLES return vectors, then walks the upper-triangle
// pairs one per cycle through cov_finalize, mirroring each result into a
// shadow matrix, and finally publishes the shadow as one snapshot.
// Ports:
//   clk_in, rst_in      : clock, asynchronous active-high reset
//   sample_in           : N_STOCKS signed returns, stock i at [i*WIDTH +: WIDTH]
//   sample_valid_in     : sample_in valid
//   sample_ready_out    : registered ready
//   matrix_out          : covariance snapshot, element [r][c] at
//                         [(r*N_STOCKS+c)*WIDTH +: WIDTH] (cov_matrix_t layout)
//   matrix_valid_out    : one-cycle pulse when matrix_out is updated
//   busy_out            : high while the pair walk is running
//   state_out           : current FSM state (cov_state_t encoding)
// Handshake: a sample transfers on a rising edge where sample_valid_in and
// sample_ready_out are both high; valid while ready is low is ignored and
// nothing is buffered. Ready is high in ACCUM and low in COMPUTE/PUBLISH.
module cov_matrix
    import cov_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int N_STOCKS    = 4,
    parameter int LOG_SAMPLES = 4
) (
    input  logic                                clk_in,
    input  logic                                rst_in,
    input  logic [N_STOCKS*WIDTH-1:0]           sample_in,
    input  logic                                sample_valid_in,
    output logic                                sample_ready_out,
    output logic [N_STOCKS*N_STOCKS*WIDTH-1:0]  matrix_out,
    output logic                                matrix_valid_out,
    output logic                                busy_out,
    output logic [1:0]                          state_out
);

    localparam int NP   = pair_count(N_STOCKS);
    localparam int SXW  = WIDTH + LOG_SAMPLES;
    localparam int SXYW = 2 * WIDTH + LOG_SAMPLES;
    localparam int CW   = LOG_SAMPLES;
    localparam int PCW  = (NP > 1) ? $clog2(NP) : 1;
    localparam int IW   = (N_STOCKS > 1) ? $clog2(N_STOCKS) : 1;

    localparam logic [PCW-1:0] PC_LAST = PCW'(NP - 1);
    localparam logic [IW-1:0]  I_LAST  = IW'(N_STOCKS - 1);

    cov_state_t      state;
    logic [CW-1:0]   cnt;
    logic [PCW-1:0]  pc;
    logic [IW-1:0]   pi;
    logic [IW-1:0]   pj;

    logic [SXW-1:0]  sum_x   [N_STOCKS];
    logic [SXYW-1:0] sum_xy  [NP];
    logic [SXW-1:0]  x_ext   [N_STOCKS];
    logic [SXYW-1:0] prod_ext[NP];
    logic [WIDTH-1:0] shadow [N_STOCKS][N_STOCKS];

    logic [WIDTH-1:0] cov;
    logic             xfer;
    logic             last_xfer;

    assign xfer      = sample_valid_in && sample_ready_out;
    // The window length is a power of two, so the counter simply wraps.
    assign last_xfer = xfer && (cnt == {CW{1'b1}});
    assign state_out = state;

    for (genvar gi = 0; gi < N_STOCKS; gi++) begin : g_ext
        assign x_ext[gi] = {{LOG_SAMPLES{sample_in[gi*WIDTH+WIDTH-1]}},
                            sample_in[gi*WIDTH +: WIDTH]};
    end

    // One multiplier per upper-triangle pair so a whole sample is folded in
    // on its transfer edge. sum_xy is indexed by the row-major pair index,
    // the same order the COMPUTE walk uses.
    for (genvar gk = 0; gk < NP; gk++) begin : g_prod
        localparam int RI = pair_row(N_STOCKS, gk);
        localparam int CJ = pair_col(N_STOCKS, gk);
        logic signed [2*WIDTH-1:0] op_a;
        logic signed [2*WIDTH-1:0] op_b;
        logic signed [2*WIDTH-1:0] prod;
        assign op_a = {{WIDTH{sample_in[RI*WIDTH+WIDTH-1]}}, sample_in[RI*WIDTH +: WIDTH]};
        assign op_b = {{WIDTH{sample_in[CJ*WIDTH+WIDTH-1]}}, sample_in[CJ*WIDTH +: WIDTH]};
        assign prod = op_a * op_b;
        assign prod_ext[gk] = {{LOG_SAMPLES{prod[2*WIDTH-1]}}, prod};
    end

    cov_finalize #(
        .WIDTH       (WIDTH),
        .LOG_SAMPLES (LOG_SAMPLES)
    ) u_finalize (
        .sum_xi (sum_x[pi]),
        .sum_xj (sum_x[pj]),
        .sum_xy (sum_xy[pc]),
        .cov    (cov)
    );

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state            <= ACCUM;
            cnt              <= '0;
            pc               <= '0;
            pi               <= '0;
            pj               <= '0;
            sample_ready_out <= 1'b0;
            matrix_valid_out <= 1'b0;
            busy_out         <= 1'b0;
            matrix_out       <= '0;
            for (int i = 0; i < N_STOCKS; i++) begin
                sum_x[i] <= '0;
            end
            for (int k = 0; k < NP; k++) begin
                sum_xy[k] <= '0;
            end
            for (int r = 0; r < N_STOCKS; r++) begin
                for (int c = 0; c < N_STOCKS; c++) begin
                    shadow[r][c] <= '0;
                end
            end
        end else begin
            matrix_valid_out <= 1'b0;
            case (state)
                ACCUM: begin
                    // Also the path that raises ready on the first edge
                    // after reset.
                    sample_ready_out <= !last_xfer;
                    if (xfer) begin
                        for (int i = 0; i < N_STOCKS; i++) begin
                            sum_x[i] <= sum_x[i] + x_ext[i];
                        end
                        for (int k = 0; k < NP; k++) begin
                            sum_xy[k] <= sum_xy[k] + prod_ext[k];
                        end
                        cnt <= cnt + 1'b1;
                    end
                    if (last_xfer) begin
                        state    <= COMPUTE;
                        busy_out <= 1'b1;
                        pc       <= '0;
                        pi       <= '0;
                        pj       <= '0;
                    end
                end

                COMPUTE: begin
                    shadow[pi][pj] <= cov;
                    shadow[pj][pi] <= cov;
                    if (pc == PC_LAST) begin
                        state    <= PUBLISH;
                        busy_out <= 1'b0;
                    end else begin
                        pc <= pc + 1'b1;
                        if (pj == I_LAST) begin
                            // Next row starts on the diagonal.
                            pi <= pi + 1'b1;
                            pj <= pi + 1'b1;
                        end else begin
                            pj <= pj + 1'b1;
                        end
                    end
                end

                PUBLISH: begin
                    for (int r = 0; r < N_STOCKS; r++) begin
                        for (int c = 0; c < N_STOCKS; c++) begin
                            matrix_out[(r*N_STOCKS+c)*WIDTH +: WIDTH] <= shadow[r][c];
                        end
                    end
                    matrix_valid_out <= 1'b1;
                    sample_ready_out <= 1'b1;
                    cnt              <= '0;
                    for (int i = 0; i < N_STOCKS; i++) begin
                        sum_x[i] <= '0;
                    end
                    for (int k = 0; k < NP; k++) begin
                        sum_xy[k] <= '0;
                    end
                    state <= ACCUM;
                end

                default: begin
                    state <= ACCUM;
                end
            endcase
        end
    end

endmodule
